axil_led_seq: RTL and testbench
===============================

Name: axil_led_seq

Overview:
- AXI4-Lite slave that drives the board's LED outputs.
- Plays a programmable bit pattern on `led_o` at a programmable bit rate.
- Forwards a divider value to the block-design LED divider through `led_div_o` and a one-cycle `led_wren_o` strobe.
- Sits downstream of the PS AXI-Lite interconnect on its own M0x port, beside the register block, with the same clock and reset.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 7, byte address width; decode uses addr[4:2].
- PRESCALE_RST, 32'd49_999_999, reset value of the PRESCALE register.

Ports:
- clk100  in  1  system clock, 100 MHz.
- rstn  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  unused.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1 each.
- S_AXI_WDATA  in  32.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1 each.
- S_AXI_BRESP  out  2  always 2'b00.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1 each.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH.
- S_AXI_ARPROT  in  3  unused.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1 each.
- S_AXI_RDATA  out  32.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1 each.
- led_o  out  1  pattern output.
- led_div_o  out  5  divider value for the BD LED counter.
- led_wren_o  out  1  one-cycle strobe when led_div_o is updated.

Behaviour:
- Reset (rstn low, async):
  - All AXI ready/valid outputs are 0.
  - RDATA = 0, led_o = 0, led_div_o = 0, led_wren_o = 0.
  - Registers take their reset values; FSM goes to IDLE.
- AXI write channel:
  - Accepts a write only when AWVALID and WVALID are both high and BVALID is low.
  - AWREADY and WREADY pulse high together for exactly one cycle.
  - The register updates on that same edge, honouring WSTRB byte lanes.
  - BVALID rises the next cycle and holds until BREADY.
  - AW and W may arrive in different cycles; neither is accepted alone.
- AXI read channel:
  - ARREADY pulses one cycle when ARVALID is high and RVALID is low.
  - RDATA/RVALID are registered the next cycle; RVALID holds until RREADY.
  - Only one read and one write are outstanding at a time; the read and write paths are independent.
- Unmapped addresses: writes are ignored; reads return 0; response is OKAY.
- Register map:
  - 0x00 CTRL (RW, reset 0): [0] run, [1] oneshot, [2] invert.
  - 0x04 PRESCALE (RW): each pattern bit lasts PRESCALE+1 cycles.
  - 0x08 PATTERN (RW, reset 0): bit 0 is played first.
  - 0x0C LEN (RW, reset 31): [4:0] pattern length minus 1.
  - 0x10 STATUS (RO): [4:0] bit index, [8] busy (state RUN), [9] done.
  - 0x14 DIV (RW, reset 0): [4:0].
- DIV behaviour: a write to DIV with WSTRB[0]=1 drives led_div_o = WDATA[4:0] and pulses led_wren_o high for exactly one cycle, in the cycle after the write edge.
- Sequencer states IDLE, RUN, DONE:
  - IDLE: led_o = invert; index = 0; prescale counter cnt = PRESCALE.
    - run=1 → RUN.
  - RUN: led_o = PATTERN[index] ^ invert, registered, so it is valid the cycle after entry.
    - cnt decrements each cycle.
    - When cnt==0: cnt reloads from the live PRESCALE; if index >= LEN, index wraps to 0 or, if oneshot, the FSM goes to DONE; otherwise index increments.
    - run=0 → IDLE the next cycle, with no completion of the current bit.
  - DONE: led_o = invert; done=1.
    - run=0 → IDLE, which clears done unless LED_SEQ_IRQ_EN is defined.
- Live-update rules:
  - PATTERN and invert writes during RUN take effect in the next cycle.
  - PRESCALE writes take effect at the next reload.
  - LEN lowered below the current index causes a wrap at the next boundary.
- Boundary cases:
  - PRESCALE=0: one bit per cycle.
  - LEN=0: bit 0 repeats.
  - PRESCALE is 32-bit and wraps naturally.
  - Reset mid-run returns to IDLE immediately.

Optional Feature:
- Macro: LED_SEQ_IRQ_EN.
- When defined:
  - Adds output port irq_o (1 bit).
  - Adds CTRL[3] irq_en.
  - irq_o = done & irq_en, registered.
  - STATUS[9] becomes write-1-to-clear at 0x10, and done is no longer cleared by run=0.
  - done set and clear in the same cycle: set wins.
- When undefined:
  - No irq_o port; CTRL[3] reads 0.
  - STATUS is fully read-only, and done clears when the FSM leaves DONE.

Test Plan:
- Reset release, then read all 6 registers → CTRL=0, PRESCALE=PRESCALE_RST, PATTERN=0, LEN=31, STATUS=0, DIV=0; led_o=0.
- Write PATTERN=0x0000_000D, LEN=3, PRESCALE=1, CTRL=1 → led_o follows 1,1,0,0,1,1,1,1 repeating, each bit 2 cycles; STATUS[8]=1.
- Same setup with CTRL=0x3 → one 8-cycle pass, then led_o=0, STATUS[9]=1, STATUS[8]=0; write CTRL=0 → STATUS=0.
- Write DIV=0x1F with WSTRB=0x1 → led_div_o=5'h1F with a single-cycle led_wren_o; DIV with WSTRB=0x0 → no strobe, no change.
- Drive AWVALID 3 cycles before WVALID, and hold BREADY low 5 cycles → AWREADY/WREADY pulse together once; BVALID held 5 cycles; a read to 0x18 returns 0 with OKAY.
- Clear run mid-bit while PRESCALE=100 → IDLE next cycle, led_o=invert, index 0. With LED_SEQ_IRQ_EN: in oneshot mode irq_o=1 after DONE; W1C on STATUS[9] → irq_o=0.

Source files
------------

// File: rtl/axil_led_seq.sv
// axil_led_seq: AXI4-Lite slave driving the board LED.
//   Plays a programmable bit pattern on led_o at a programmable bit rate and
//   forwards a 5-bit divider value (led_div_o + one-cycle led_wren_o strobe)
//   to the block-design LED counter.
// Ports:
//   clk100, rstn        clock, asynchronous active-low reset
//   S_AXI_*             AXI4-Lite slave (one outstanding read, one write)
//   led_o               pattern output
//   led_div_o           divider value, led_wren_o strobes one cycle on update
//   irq_o               (only with LED_SEQ_IRQ_EN) done & irq_en, registered
// Optional feature macro: LED_SEQ_IRQ_EN
//   Adds irq_o, CTRL[3] irq_en, and makes STATUS[9] (done) write-1-to-clear;
//   without it, done simply mirrors the DONE state.
module axil_led_seq #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 7,
    parameter logic [31:0] PRESCALE_RST       = 32'd49_999_999
) (
    input  logic                            clk100,
    input  logic                            rstn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [3:0]                      S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            led_o,
    output logic [4:0]                      led_div_o,
    output logic                            led_wren_o
`ifdef LED_SEQ_IRQ_EN
    ,
    output logic                            irq_o
`endif
);

`ifdef LED_SEQ_IRQ_EN
    localparam int CTRL_W = 4;
`else
    localparam int CTRL_W = 3;
`endif

    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_PRESC = 3'd1;
    localparam logic [2:0] A_PATT  = 3'd2;
    localparam logic [2:0] A_LEN   = 3'd3;
    localparam logic [2:0] A_STAT  = 3'd4;
    localparam logic [2:0] A_DIV   = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction

    logic              awready_q, bvalid_q, arready_q, rvalid_q;
    logic [31:0]       rdata_q, rd_mux;
    logic [CTRL_W-1:0] ctrl_q;
    logic [31:0]       prescale_q, pattern_q, cnt_q, cnt_d;
    logic [4:0]        len_q, div_q, idx_q, idx_d;
    logic              wren_q, led_q, led_d, done_q, done_d, done_set;
    state_t            state_q, state_d;

    logic       wr_en;
    logic [2:0] wr_sel;
    logic       run, oneshot, invert;

    assign run     = ctrl_q[0];
    assign oneshot = ctrl_q[1];
    assign invert  = ctrl_q[2];

    // Write is committed on the edge where AWREADY/WREADY are high.
    assign wr_en  = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign wr_sel = S_AXI_AWADDR[4:2];

    // AXI handshake state.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            // ~awready_q keeps the ready a single-cycle pulse.
            awready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
            if (wr_en)
                bvalid_q <= 1'b1;
            else if (S_AXI_BREADY)
                bvalid_q <= 1'b0;

            arready_q <= S_AXI_ARVALID & ~rvalid_q & ~arready_q;
            if (arready_q && S_AXI_ARVALID) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Register file.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            ctrl_q     <= '0;
            prescale_q <= PRESCALE_RST;
            pattern_q  <= '0;
            len_q      <= 5'd31;
            div_q      <= '0;
            wren_q     <= 1'b0;
        end else begin
            wren_q <= 1'b0;
            if (wr_en) begin
                case (wr_sel)
                    A_CTRL:  if (S_AXI_WSTRB[0]) ctrl_q <= S_AXI_WDATA[CTRL_W-1:0];
                    A_PRESC: prescale_q <= apply_strb(prescale_q, S_AXI_WDATA, S_AXI_WSTRB);
                    A_PATT:  pattern_q  <= apply_strb(pattern_q, S_AXI_WDATA, S_AXI_WSTRB);
                    A_LEN:   if (S_AXI_WSTRB[0]) len_q <= S_AXI_WDATA[4:0];
                    A_DIV: begin
                        if (S_AXI_WSTRB[0]) begin
                            div_q  <= S_AXI_WDATA[4:0];
                            wren_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        led_d    = invert;
        done_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                cnt_d = prescale_q;
                if (run) state_d = S_RUN;
            end
            S_RUN: begin
                led_d = pattern_q[idx_q] ^ invert;
                if (!run) begin
                    // Abandon the current bit immediately.
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = prescale_q;
                end else if (cnt_q == 32'd0) begin
                    cnt_d = prescale_q;
                    // >= so that lowering LEN below the index wraps at the next boundary.
                    if (idx_q >= len_q) begin
                        idx_d = '0;
                        if (oneshot) begin
                            state_d  = S_DONE;
                            done_set = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_DONE: begin
                idx_d = '0;
                cnt_d = prescale_q;
                if (!run) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef LED_SEQ_IRQ_EN
        // Set has priority over a simultaneous write-1-to-clear.
        done_d = done_set | (done_q & ~(wr_en && wr_sel == A_STAT &&
                                        S_AXI_WSTRB[1] && S_AXI_WDATA[9]));
`else
        done_d = done_set | (done_q & (state_d == S_DONE));
`endif
    end

    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= PRESCALE_RST;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            done_q  <= done_d;
        end
    end

`ifdef LED_SEQ_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) irq_q <= 1'b0;
        else       irq_q <= done_q & ctrl_q[3];
    end
    assign irq_o = irq_q;
`endif

    // Read data mux; unmapped offsets read as zero.
    always_comb begin
        rd_mux = '0;
        case (S_AXI_ARADDR[4:2])
            A_CTRL:  rd_mux = {{(32-CTRL_W){1'b0}}, ctrl_q};
            A_PRESC: rd_mux = prescale_q;
            A_PATT:  rd_mux = pattern_q;
            A_LEN:   rd_mux = {27'd0, len_q};
            A_STAT:  rd_mux = {22'd0, done_q, (state_q == S_RUN), 3'd0, idx_q};
            A_DIV:   rd_mux = {27'd0, div_q};
            default: rd_mux = '0;
        endcase
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:5], S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:5], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign led_o         = led_q;
    assign led_div_o     = div_q;
    assign led_wren_o    = wren_q;

endmodule

// File: tb/tb_axil_led_seq.sv
// Self-checking bench for axil_led_seq: register reset values, pattern playback,
// oneshot, prescale 0, DIV strobe, split AW/W handshake, unmapped read, run abort,
// and (with LED_SEQ_IRQ_EN) the interrupt path.
module tb_axil_led_seq;

    localparam logic [31:0] PRESCALE_RST = 32'd49_999_999;

    logic        clk = 1'b0;
    logic        rstn;
    logic [6:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        led_o, led_wren_o;
    logic [4:0]  led_div_o;
`ifdef LED_SEQ_IRQ_EN
    logic        irq_o;
`endif

    always #5 clk = ~clk;

    axil_led_seq #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(7),
        .PRESCALE_RST(PRESCALE_RST)
    ) dut (
`ifdef LED_SEQ_IRQ_EN
        .irq_o(irq_o),
`endif
        .clk100(clk), .rstn(rstn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready), .led_o(led_o), .led_div_o(led_div_o),
        .led_wren_o(led_wren_o)
    );

    int checks = 0;
    int errors = 0;
    int wren_cnt = 0;

    always @(negedge clk) if (led_wren_o === 1'b1) wren_cnt++;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } rd_exp_t;

    rd_exp_t rd_sb[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic axi_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        if (!awready) chk("write awready timeout", {31'd0, awready}, 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (!bvalid) chk("write bvalid timeout", {31'd0, bvalid}, 32'd1);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    // Expected value is queued when the read is issued and popped when RVALID appears.
    task automatic axi_read(input logic [6:0] addr, input logic [31:0] exp,
                            input logic [31:0] mask, input string name);
        rd_exp_t e;
        int n;
        e.addr = addr; e.exp = exp; e.mask = mask; e.name = name;
        rd_sb.push_back(e);
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (!arready) chk({name, " arready timeout"}, {31'd0, arready}, 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        if (!rvalid) chk({name, " rvalid timeout"}, {31'd0, rvalid}, 32'd1);
        e = rd_sb.pop_front();
        chk(e.name, rdata & e.mask, e.exp & e.mask);
        chk({e.name, " rresp"}, {30'd0, rresp}, 32'd0);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    // Waits for the first high led_o, then compares n consecutive cycles to bits[0..n-1].
    task automatic check_led(input logic [15:0] bits, input int n, input string name);
        logic exp_q[$];
        logic e;
        int k = 0;
        while (led_o !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        chk({name, " start"}, {31'd0, led_o}, 32'd1);
        for (int i = 0; i < n; i++) exp_q.push_back(bits[i]);
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            chk($sformatf("%s[%0d]", name, i), {31'd0, led_o}, {31'd0, e});
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] exp;
        string       name;
    } rst_vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_vec_t vec[6];
        int base, aw_early, pulses, split, bhold;

        vec[0] = '{7'h00, 32'h0, "rst CTRL"};
        vec[1] = '{7'h04, PRESCALE_RST, "rst PRESCALE"};
        vec[2] = '{7'h08, 32'h0, "rst PATTERN"};
        vec[3] = '{7'h0C, 32'd31, "rst LEN"};
        vec[4] = '{7'h10, 32'h0, "rst STATUS"};
        vec[5] = '{7'h14, 32'h0, "rst DIV"};

        rstn = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst ready/valid", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst led", {25'd0, led_o, led_wren_o, led_div_o}, 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < 6; i++) axi_read(vec[i].addr, vec[i].exp, 32'hFFFF_FFFF, vec[i].name);
        chk("led after reset", {31'd0, led_o}, 32'd0);

        // Repeating pattern 0xD, 4 bits, 2 cycles per bit.
        axi_write(7'h08, 32'h0000_000D, 4'hF);
        axi_write(7'h0C, 32'd3, 4'hF);
        axi_write(7'h04, 32'd1, 4'hF);
        axi_write(7'h00, 32'd1, 4'hF);
        check_led(16'hF3F3, 16, "repeat");
        axi_read(7'h10, 32'h100, 32'h300, "status busy");
        axi_write(7'h00, 32'd0, 4'hF);

        // Oneshot: one pass then led falls and done is reported.
        axi_write(7'h00, 32'd3, 4'hF);
        check_led(16'h00F3, 9, "oneshot");
        axi_read(7'h10, 32'h200, 32'h300, "status done");
        axi_write(7'h00, 32'd0, 4'hF);
`ifdef LED_SEQ_IRQ_EN
        axi_read(7'h10, 32'h200, 32'hFFFF_FFFF, "status done sticky");
        axi_write(7'h10, 32'h200, 4'h2);
`endif
        axi_read(7'h10, 32'h0, 32'hFFFF_FFFF, "status idle");

        // PRESCALE=0: one bit per cycle.
        axi_write(7'h04, 32'd0, 4'hF);
        axi_write(7'h0C, 32'd1, 4'hF);
        axi_write(7'h08, 32'd1, 4'hF);
        axi_write(7'h00, 32'd1, 4'hF);
        check_led(16'h0015, 6, "presc0");
        axi_write(7'h00, 32'd0, 4'hF);

        // DIV strobe.
        base = wren_cnt;
        axi_write(7'h14, 32'h1F, 4'h1);
        repeat (2) @(negedge clk);
        chk("div wren pulses", wren_cnt - base, 32'd1);
        chk("div value", {27'd0, led_div_o}, 32'h1F);
        axi_write(7'h14, 32'h0A, 4'h0);
        repeat (2) @(negedge clk);
        chk("div nostrb pulses", wren_cnt - base, 32'd1);
        chk("div nostrb value", {27'd0, led_div_o}, 32'h1F);
        axi_read(7'h14, 32'h1F, 32'hFFFF_FFFF, "div readback");

        // AW three cycles ahead of W, BREADY held low.
        @(negedge clk);
        awaddr = 7'h08; wdata = 32'hA5; wstrb = 4'hF; awvalid = 1'b1;
        aw_early = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (awready || wready) aw_early++;
        end
        chk("aw alone not accepted", aw_early, 32'd0);
        wvalid = 1'b1;
        pulses = 0; split = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (awready && wready) pulses++;
            if (awready != wready) split++;
            if (bvalid) begin awvalid = 1'b0; wvalid = 1'b0; end
        end
        chk("aw/w pulse count", pulses, 32'd1);
        chk("aw/w split", split, 32'd0);
        bhold = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bvalid) bhold++;
        end
        chk("bvalid hold", bhold, 32'd5);
        chk("bresp", {30'd0, bresp}, 32'd0);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid cleared", {31'd0, bvalid}, 32'd0);
        axi_read(7'h18, 32'h0, 32'hFFFF_FFFF, "unmapped read");
        axi_read(7'h08, 32'hA5, 32'hFFFF_FFFF, "split write data");

        // Abort mid-bit with invert set.
        axi_write(7'h08, 32'h0000_000D, 4'hF);
        axi_write(7'h04, 32'd100, 4'hF);
        axi_write(7'h00, 32'd5, 4'hF);
        repeat (10) @(negedge clk);
        chk("run inverted bit0", {31'd0, led_o}, 32'd0);
        axi_write(7'h00, 32'd4, 4'hF);
        @(negedge clk);
        chk("abort led=invert", {31'd0, led_o}, 32'd1);
        axi_read(7'h10, 32'h0, 32'hFFFF_FFFF, "abort status");

`ifdef LED_SEQ_IRQ_EN
        begin
            int k;
            axi_write(7'h0C, 32'd3, 4'hF);
            axi_write(7'h04, 32'd1, 4'hF);
            axi_write(7'h00, 32'hB, 4'hF);
            k = 0;
            while (irq_o !== 1'b1 && k < 60) begin @(negedge clk); k++; end
            chk("irq set", {31'd0, irq_o}, 32'd1);
            axi_write(7'h10, 32'h200, 4'h2);
            repeat (2) @(negedge clk);
            chk("irq cleared", {31'd0, irq_o}, 32'd0);
            axi_write(7'h00, 32'd0, 4'hF);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
